// File: rtl/apb_pkg.sv
// Shared types, default widths and helpers for the parametrised APB master
// and its per-slave response mux.
package apb_pkg;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_NUM_SLV = 4;
  localparam int APB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Combinational selection of one slave's PREADY/PSLVERR/PRDATA by index.
// Indices with no matching slave return all zeros.
module apb_slave_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int DATA_W  = APB_DATA_W
) (
  input  logic [clog2(NUM_SLV)-1:0] i_idx,
  input  logic [NUM_SLV-1:0]        i_pready,
  input  logic [NUM_SLV-1:0]        i_pslverr,
  input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
  output logic                      o_ready,
  output logic                      o_slvErr,
  output logic [DATA_W-1:0]         o_rdata
);

  localparam int SEL_W = clog2(NUM_SLV);

  always_comb begin
    o_ready  = 1'b0;
    o_slvErr = 1'b0;
    o_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (i_idx == SEL_W'(i)) begin
        o_ready  = i_pready[i];
        o_slvErr = i_pslverr[i];
        o_rdata  = i_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB master serving NUM_SLV slaves: one request at a time, address-decoded
// slave select, wait-state timeout and a single-cycle response strobe.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA
);

  localparam int               SEL_W        = clog2(NUM_SLV);
  localparam logic [SEL_W:0]   SLV_COUNT    = (SEL_W+1)'(NUM_SLV);
  localparam logic [7:0]       TIMEOUT_LAST = 8'(TIMEOUT - 1);

  apb_state_e         r_state;
  logic [SEL_W-1:0]   r_idx;
  logic [7:0]         r_waitCnt;

  logic [SEL_W-1:0]   w_reqIdx;
  logic               w_reqDecodeOk;
  logic [NUM_SLV-1:0] w_reqOneHot;
  logic               w_selReady;
  logic               w_selSlvErr;
  logic [DATA_W-1:0]  w_selRdata;

  assign w_reqIdx      = req_addr[ADDR_W-1 -: SEL_W];
  assign w_reqDecodeOk = {1'b0, w_reqIdx} < SLV_COUNT;
  assign w_reqOneHot   = NUM_SLV'(1) << w_reqIdx;
  assign req_ready     = (r_state == IDLE) && !PRESET;

  apb_slave_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W)
  ) u_slaveMux (
    .i_idx     (r_idx),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR),
    .i_prdata  (PRDATA),
    .o_ready   (w_selReady),
    .o_slvErr  (w_selSlvErr),
    .o_rdata   (w_selRdata)
  );

  // The response strobe defaults low every cycle so it can only ever pulse.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_waitCnt <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (w_reqDecodeOk) begin
              r_state   <= SETUP;
              r_idx     <= w_reqIdx;
              r_waitCnt <= '0;
              PADDR     <= req_addr;
              PWDATA    <= req_wdata;
              PWRITE    <= req_write;
              PSEL      <= w_reqOneHot;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (w_selReady) begin
            r_state   <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= w_selSlvErr;
            rsp_rdata <= (!PWRITE && !w_selSlvErr) ? w_selRdata : '0;
          end else if (r_waitCnt == TIMEOUT_LAST) begin
            // Stalled slave: abort before the counter could ever wrap.
            r_state   <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
